ctrl_conv_input: RTL
====================

Name: ctrl_conv_input

Overview:
- Input-side controller for the convolution datapath; the receiving end of the AXI-stream X and F inputs, complementing the output-side controller that drives m_valid_y.
- Accepts X and F samples via valid/ready handshakes and generates write enables and addresses for X_mem and F_mem.
- Raises conv_start once both memories are full, then holds off further input until the output controller pulses conv_done.

Parameters:
- F_MEM_SIZE, 4, number of filter coefficients in F_mem.
- X_MEM_SIZE, 8, number of input samples in X_mem.
- X_MEM_ADDR_WIDTH, 3, X_mem address width (ceil(log2(X_MEM_SIZE))).
- F_MEM_ADDR_WIDTH, 2, F_mem address width (ceil(log2(F_MEM_SIZE))).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- s_valid_x  input  1  X sample valid from upstream master.
- s_ready_x  output  1  X sample accepted when s_valid_x & s_ready_x.
- s_valid_f  input  1  F coefficient valid from upstream master.
- s_ready_f  output  1  F coefficient accepted when s_valid_f & s_ready_f.
- wr_en_x  output  1  X_mem write enable.
- wr_addr_x  output  X_MEM_ADDR_WIDTH  X_mem write address.
- wr_en_f  output  1  F_mem write enable.
- wr_addr_f  output  F_MEM_ADDR_WIDTH  F_mem write address.
- conv_start  output  1  level: both memories full, convolution may run.
- conv_done  input  1  one-cycle pulse from output controller: convolution finished.

Behaviour:
- Reset (asynchronous, active-low):
  - While reset=0: s_ready_x=0, s_ready_f=0, conv_start=0, wr_addr_x=0, wr_addr_f=0, x_full=0, f_full=0, state=LOAD.
  - wr_en_x and wr_en_f are 0 because the readies are 0.
- Reset mid-operation: discards all partial loads. First cycle after release: s_ready_x=1, s_ready_f=1.
- State LOAD:
  - s_ready_x and s_ready_f are registered. Each is 1 while its memory is not full.
  - wr_en_x = s_valid_x & s_ready_x, combinational. wr_en_f likewise.
  - On an X handshake: wr_addr_x increments.
    - If wr_addr_x == X_MEM_SIZE-1: wr_addr_x wraps to 0, x_full<=1 and s_ready_x<=0 at the same edge, so no extra beat is accepted.
  - F handshakes behave the same way with F_MEM_SIZE, wr_addr_f and f_full.
  - X and F handshakes are independent and may occur in the same cycle; both are accepted.
  - A stalled beat (valid=1, ready=0) changes nothing.
  - When x_full & f_full are both registered high: at the next edge conv_start<=1 and state<=CONV.
  - Latency: the final accepted beat is at edge E; conv_start is 1 after edge E+1.
  - conv_done is ignored in LOAD.
- State CONV:
  - s_ready_x=0, s_ready_f=0, conv_start=1.
  - On conv_done=1 at an edge:
    - conv_start<=0, x_full<=0, f_full<=0.
    - s_ready_x<=1, s_ready_f<=1, state<=LOAD.
  - conv_start therefore drops one cycle after the conv_done pulse, so the output controller sees conv_start=0 by the time its conv_done clears.
- Addresses always wrap modulo memory size.
- No input is accepted while a convolution runs; upstream back-pressure holds data.

Optional Feature:
- Macro: CTRL_CONV_INPUT_KEEP_F_EN.
- Defined:
  - F_mem contents persist across convolutions.
  - On conv_done only x_full clears and only s_ready_x returns to 1.
  - f_full stays 1 and s_ready_f stays 0 until the next reset.
  - Later convolutions need only X_MEM_SIZE new X beats.
- Undefined: both memories are reloaded after every conv_done, as described above.

Test Plan:
- Release reset with s_valid_x=s_valid_f=1 continuously:
  - wr_addr_x steps 0..7 and wr_addr_f steps 0..3, one beat per cycle.
  - s_ready_f falls after 4 beats; s_ready_x falls after 8 beats.
  - conv_start rises one cycle after the 8th X beat.
- Random valid gaps on X and F (e.g., valid every 3rd cycle):
  - Exactly 8 X and 4 F writes occur, at addresses in order.
  - No write occurs while ready=0.
- In CONV, hold s_valid_x=1 and pulse conv_done for 1 cycle:
  - No writes occur before the pulse.
  - conv_start=0 and s_ready_x=s_ready_f=1 the following cycle.
  - A second load restarts at address 0.
- Assert reset=0 after 5 X beats and 2 F beats, then release:
  - Addresses are back at 0 and readies are 1.
  - A full new load is required before conv_start.
- Pulse conv_done during LOAD: no effect on counters, readies or conv_start.
- With CTRL_CONV_INPUT_KEEP_F_EN defined, complete one convolution:
  - After conv_done only s_ready_x=1.
  - conv_start returns after 8 X beats with no F beats.

Source files
------------

// File: rtl/ctrl_conv_input.sv
// ctrl_conv_input: input-side X/F load controller for the convolution datapath.
// Optional macro CTRL_CONV_INPUT_KEEP_F_EN keeps F_mem loaded across convolutions.
module ctrl_conv_input #(
  parameter int F_MEM_SIZE = 4,
  parameter int X_MEM_SIZE = 8,
  parameter int X_MEM_ADDR_WIDTH = 3,
  parameter int F_MEM_ADDR_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid_x,
  output logic                        s_ready_x,
  input  logic                        s_valid_f,
  output logic                        s_ready_f,
  output logic                        wr_en_x,
  output logic [X_MEM_ADDR_WIDTH-1:0] wr_addr_x,
  output logic                        wr_en_f,
  output logic [F_MEM_ADDR_WIDTH-1:0] wr_addr_f,
  output logic                        conv_start,
  input  logic                        conv_done
);
  typedef enum logic {LOAD, CONV} state_t;
  state_t state;
  logic x_full, f_full, last_x, last_f;
  assign wr_en_x = s_valid_x & s_ready_x;
  assign wr_en_f = s_valid_f & s_ready_f;
  assign last_x = wr_addr_x == X_MEM_ADDR_WIDTH'(X_MEM_SIZE - 1);
  assign last_f = wr_addr_f == F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= LOAD;
      s_ready_x  <= 1'b0;
      s_ready_f  <= 1'b0;
      conv_start <= 1'b0;
      wr_addr_x  <= '0;
      wr_addr_f  <= '0;
      x_full     <= 1'b0;
      f_full     <= 1'b0;
    end else if (state == LOAD) begin
      if (wr_en_x) wr_addr_x <= last_x ? '0 : wr_addr_x + 1'b1;
      if (wr_en_f) wr_addr_f <= last_f ? '0 : wr_addr_f + 1'b1;
      if (wr_en_x && last_x) x_full <= 1'b1;
      if (wr_en_f && last_f) f_full <= 1'b1;
      // ready drops on the same edge as the final beat so no extra beat slips in
      s_ready_x <= !(x_full || (wr_en_x && last_x));
      s_ready_f <= !(f_full || (wr_en_f && last_f));
      if (x_full && f_full) begin
        conv_start <= 1'b1;
        state      <= CONV;
      end
    end else if (conv_done) begin
      conv_start <= 1'b0;
      x_full     <= 1'b0;
      s_ready_x  <= 1'b1;
      state      <= LOAD;
`ifdef CTRL_CONV_INPUT_KEEP_F_EN
      s_ready_f  <= 1'b0;
`else
      f_full     <= 1'b0;
      s_ready_f  <= 1'b1;
`endif
    end
endmodule
